// File: rtl/uart_prog_loader.sv
// ---------------------------------------------------------------------------
// uart_prog_loader
//
// Boot-time program loader. It receives program words as a stream of UART
// bytes and writes them to memory. The CPU is held in reset until the load
// has finished.
//
// Bytes are packed MSB first into words of WORD_BYTES bytes. Each word is
// written to consecutive addresses, starting at BASE_ADDR and advancing by
// WORD_BYTES. The word END_WORD ends the load and is never written to memory.
// If GAP_CYC is non-zero, a partly received word is thrown away when the line
// stays quiet for GAP_CYC cycles. This keeps the byte phase aligned after a
// glitch on the line.
//
// Optional feature, selected by the macro LOADER_CHECKSUM_EN:
//   After END_WORD, one more byte is expected. It must equal the 8-bit sum of
//   all bytes of the written words. Any other byte, or a gap timeout while
//   waiting for it, aborts the load.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx_prog    in   sampled once after reset: 1 = load, 0 = skip loading
//   rx_valid   in   one-cycle strobe, rx_byte holds a received byte
//   rx_byte    in   [7:0] received byte
//   mem_addr   out  [AW-1:0] write address
//   mem_wdata  out  [DW-1:0] write data
//   mem_wr     out  write request, held until mem_ack
//   mem_ack    in   memory accepted the write this cycle
//   cpu_hold   out  keeps the CPU in reset while 1
//   done       out  load finished successfully
//   err        out  load aborted (sticky until reset)
//   word_cnt   out  [AW-1:0] number of words written
// ---------------------------------------------------------------------------
module uart_prog_loader #(
    parameter int                      AW         = 16,
    parameter int                      WORD_BYTES = 2,
    parameter logic [AW-1:0]           BASE_ADDR  = 'h300,
    parameter logic [8*WORD_BYTES-1:0] END_WORD   = 'h7fff,
    parameter int                      GAP_CYC    = 270000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_prog,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_byte,
    output logic [AW-1:0]             mem_addr,
    output logic [8*WORD_BYTES-1:0]   mem_wdata,
    output logic                      mem_wr,
    input  logic                      mem_ack,
    output logic                      cpu_hold,
    output logic                      done,
    output logic                      err,
    output logic [AW-1:0]             word_cnt
);

    localparam int DW = 8 * WORD_BYTES;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
    // The gap counter expires on the GAP_CYC-th silent cycle after the last byte.
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;
    localparam logic [1:0]    PH_LAST  = 2'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic            mem_wr_q;
    logic            cpu_hold_q;
    logic            done_q;
    logic            err_q;
    logic [AW-1:0]   word_cnt_q;
    logic [DW-1:0]   shift_q;      // bytes of the word being assembled
    logic [1:0]      phase_q;      // number of bytes already in shift_q
    logic [GW-1:0]   gap_q;        // silent cycles since the last byte
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum_q;       // running sum of the bytes of written words
    logic [7:0]      wsum_q;       // sum of the bytes of the partial word
`endif

    logic [DW-1:0]   word_d;
    logic            last_byte;
    logic            gap_expire;

    // The new byte goes into the LSB end. For WORD_BYTES = 1 the cast drops
    // shift_q completely.
    assign word_d     = DW'({shift_q, rx_byte});
    assign last_byte  = (phase_q == PH_LAST);
    assign gap_expire = (GAP_CYC != 0) && !rx_valid && (gap_q == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            word_cnt_q  <= '0;
            shift_q     <= '0;
            phase_q     <= '0;
            gap_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
            wsum_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_prog) begin
                        state_q <= S_RECV;
                    end else begin
                        state_q    <= S_DONE;
                        cpu_hold_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end

                // RECV and WRITE share the byte assembler, so the next word can
                // arrive while a write is still waiting for its ack.
                S_RECV, S_WRITE: begin
                    if (rx_valid) begin
                        gap_q <= '0;
                    end else if (GAP_CYC != 0 && phase_q != 2'd0) begin
                        if (gap_expire) begin
                            phase_q <= '0;
                            shift_q <= '0;
                            gap_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
                            wsum_q  <= '0;
`endif
                        end else begin
                            gap_q <= gap_q + GW'(1);
                        end
                    end

                    if (state_q == S_WRITE && mem_ack) begin
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= mem_addr_q + AW'(WORD_BYTES);
                        word_cnt_q <= word_cnt_q + AW'(1);
                        state_q    <= S_RECV;
                    end

                    if (rx_valid) begin
                        if (!last_byte) begin
                            shift_q <= word_d;
                            phase_q <= phase_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            wsum_q  <= wsum_q + rx_byte;
`endif
                        end else begin
                            phase_q <= '0;
                            shift_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                            wsum_q  <= '0;
`endif
                            if (state_q == S_WRITE) begin
                                // There is only one write slot. A second
                                // complete word cannot be held, so this is an
                                // overrun, even if the ack comes in this cycle.
                                state_q  <= S_ERROR;
                                err_q    <= 1'b1;
                                mem_wr_q <= 1'b0;
                            end else if (word_d == END_WORD) begin
                                state_q <= S_CHECK;
                                gap_q   <= '0;
                            end else begin
                                mem_wdata_q <= word_d;
                                mem_wr_q    <= 1'b1;
                                state_q     <= S_WRITE;
`ifdef LOADER_CHECKSUM_EN
                                csum_q      <= csum_q + wsum_q + rx_byte;
`endif
                            end
                        end
                    end
                end

                S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (rx_valid) begin
                        if (rx_byte == csum_q) begin
                            state_q    <= S_DONE;
                            cpu_hold_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end else if (GAP_CYC != 0) begin
                        if (gap_q == GAP_LAST) begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            gap_q <= gap_q + GW'(1);
                        end
                    end
`else
                    state_q    <= S_DONE;
                    cpu_hold_q <= 1'b0;
                    done_q     <= 1'b1;
`endif
                end

                // DONE and ERROR are terminal; only reset leaves them.
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Directed testbench for uart_prog_loader with a scoreboard.
// The stimulus pushes each expected memory write into exp_q.
// A separate monitor pops exp_q on every acknowledged write and compares
// address, data, how long mem_wr was held, and whether address/data stayed
// stable while it was held.
// A responder process drives mem_ack after hold_cyc cycles of mem_wr
// (hold_cyc = 0 means the write is never acknowledged).
// ---------------------------------------------------------------------------
module tb_uart_prog_loader;

    localparam int GAP = 20;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        rx_prog  = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte  = 8'h00;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wr;
    logic        mem_ack  = 1'b0;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] word_cnt;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  hold_cyc = 1;
    int  exp_hold = 1;
    bit  wr_ever  = 1'b0;

    uart_prog_loader #(
        .AW         (16),
        .WORD_BYTES (2),
        .BASE_ADDR  (16'h0300),
        .END_WORD   (16'h7fff),
        .GAP_CYC    (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_prog   (rx_prog),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_ack   (mem_ack),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: mem_ack goes high on the hold_cyc-th cycle of mem_wr.
    initial begin : responder
        int rc;
        rc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_wr === 1'b1) begin
                mem_ack = (hold_cyc != 0) && (rc >= hold_cyc - 1);
                rc++;
            end else begin
                mem_ack = 1'b0;
                rc = 0;
            end
        end
    end

    // Monitor: checks each acknowledged write against the scoreboard.
    initial begin : monitor
        int          hi;
        logic        stable;
        logic [15:0] ca;
        logic [15:0] cd;
        wr_t         e;
        hi = 0;
        stable = 1'b1;
        ca = '0;
        cd = '0;
        forever begin
            @(negedge clk);
            if (mem_wr === 1'b1) begin
                wr_ever = 1'b1;
                if (hi == 0) begin
                    ca = mem_addr;
                    cd = mem_wdata;
                    stable = 1'b1;
                end else if (mem_addr !== ca || mem_wdata !== cd) begin
                    stable = 1'b0;
                end
                hi++;
                if (mem_ack === 1'b1) begin
                    $display("write addr=%h data=%h held=%0d", mem_addr, mem_wdata, hi);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got %h@%h, expected none", mem_wdata, mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(e.a));
                        chk("wr_data", 32'(mem_wdata), 32'(e.d));
                        chk("wr_hold_cycles", 32'(hi), 32'(exp_hold));
                        chk("wr_stable", 32'(stable), 32'd1);
                    end
                    hi = 0;
                end
            end else begin
                hi = 0;
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_rst_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_rst_done"}, 32'(done), 32'd0);
        chk({tag, "_rst_err"}, 32'(err), 32'd0);
        chk({tag, "_rst_mem_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, "_rst_mem_addr"}, 32'(mem_addr), 32'h300);
        chk({tag, "_rst_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_rst_word_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    // Assert reset, check the reset values without waiting for a clock edge,
    // then release reset on a falling edge.
    task automatic do_reset(input string tag, input logic prog);
        rst_n = 1'b0;
        #1;
        chk_reset(tag);
        @(negedge clk);
        rx_prog = prog;
        wr_ever = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("rx byte %h", b);
    endtask

    task automatic wait_wr_done(input string tag);
        int k;
        k = 0;
        while (mem_wr === 1'b1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_wr_release"}, 32'(mem_wr), 32'd0);
    endtask

    task automatic wait_end();
        int k;
        k = 0;
        while (done !== 1'b1 && err !== 1'b1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        #3;

        // T1: skip loading.
        hold_cyc = 1;
        do_reset("t1", 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        repeat (5) @(negedge clk);
        chk("t1_no_write", 32'(wr_ever), 32'd0);
        chk("t1_word_cnt", 32'(word_cnt), 32'd0);

        // T2: two words, ack in the same cycle as mem_wr.
        hold_cyc = 1;
        exp_hold = 1;
        do_reset("t2", 1'b1);
        exp_q.push_back('{a: 16'h0300, d: 16'h1234});
        exp_q.push_back('{a: 16'h0302, d: 16'habcd});
        send_byte(8'h12);
        send_byte(8'h34);
        wait_wr_done("t2a");
        send_byte(8'hab);
        send_byte(8'hcd);
        wait_wr_done("t2b");
        send_byte(8'h7f);
        send_byte(8'hff);
        wait_end();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_err", 32'(err), 32'd0);
        chk("t2_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("t2_word_cnt", 32'(word_cnt), 32'd2);
        chk("t2_next_addr", 32'(mem_addr), 32'h304);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // T3: ack delayed, mem_wr held for 5 cycles with stable address/data.
        hold_cyc = 5;
        exp_hold = 5;
        do_reset("t3", 1'b1);
        exp_q.push_back('{a: 16'h0300, d: 16'haa55});
        send_byte(8'haa);
        send_byte(8'h55);
        wait_wr_done("t3");
        send_byte(8'h7f);
        send_byte(8'hff);
        wait_end();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_word_cnt", 32'(word_cnt), 32'd1);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // T4: a second word completes before the ack, which is an overrun.
        hold_cyc = 0;
        do_reset("t4", 1'b1);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("t4_wr_pending", 32'(mem_wr), 32'd1);
        send_byte(8'h56);
        send_byte(8'h78);
        wait_end();
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("t4_mem_wr", 32'(mem_wr), 32'd0);
        chk("t4_word_cnt", 32'(word_cnt), 32'd0);
        send_byte(8'h7f);
        send_byte(8'hff);
        chk("t4_err_sticky", 32'(err), 32'd1);
        chk("t4_done_after", 32'(done), 32'd0);

        // T5: the byte before a long gap is discarded.
        hold_cyc = 1;
        exp_hold = 1;
        do_reset("t5", 1'b1);
        exp_q.push_back('{a: 16'h0300, d: 16'h3456});
        send_byte(8'h12);
        repeat (GAP + 1) @(posedge clk);
        #1;
        send_byte(8'h34);
        send_byte(8'h56);
        wait_wr_done("t5");
        send_byte(8'h7f);
        send_byte(8'hff);
        wait_end();
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_word_cnt", 32'(word_cnt), 32'd1);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // T6: reset while a write is pending.
        hold_cyc = 0;
        do_reset("t6", 1'b1);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("t6_wr_before_reset", 32'(mem_wr), 32'd1);
        chk("t6_addr_before_reset", 32'(mem_addr), 32'h300);
        chk("t6_data_before_reset", 32'(mem_wdata), 32'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_mem_wr", 32'(mem_wr), 32'd0);
        chk("t6_mem_addr", 32'(mem_addr), 32'h300);
        chk("t6_word_cnt", 32'(word_cnt), 32'd0);
        chk("t6_cpu_hold", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

`ifdef LOADER_CHECKSUM_EN
        // T7: checksum byte matches the sum 12+34 = 46.
        hold_cyc = 1;
        exp_hold = 1;
        do_reset("t7", 1'b1);
        exp_q.push_back('{a: 16'h0300, d: 16'h1234});
        send_byte(8'h12);
        send_byte(8'h34);
        wait_wr_done("t7");
        send_byte(8'h7f);
        send_byte(8'hff);
        chk("t7_wait_csum", 32'(done), 32'd0);
        send_byte(8'h46);
        wait_end();
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_err", 32'(err), 32'd0);

        // T8: the checksum byte is wrong.
        do_reset("t8", 1'b1);
        exp_q.push_back('{a: 16'h0300, d: 16'h1234});
        send_byte(8'h12);
        send_byte(8'h34);
        wait_wr_done("t8");
        send_byte(8'h7f);
        send_byte(8'hff);
        send_byte(8'h47);
        wait_end();
        chk("t8_err", 32'(err), 32'd1);
        chk("t8_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("t8_done", 32'(done), 32'd0);
        chk("t8_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
